// File: rtl/xor_result_buffer_pkg.sv
// Shared constants for the XOR result buffer.
//   DefaultW      : default data width, matches the upstream XOR stage result
//   DefaultDepth  : default FIFO depth (power of two, >= 2)
//   DefaultCountW : occupancy counter width for the default depth
//   DropCntW      : width of the saturating drop counter
//   count_width() : occupancy counter width for an arbitrary depth
package xor_result_buffer_pkg;

    localparam int unsigned DefaultW      = 20;
    localparam int unsigned DefaultDepth  = 4;
    localparam int unsigned DefaultCountW = $clog2(DefaultDepth) + 1;
    localparam int unsigned DropCntW      = 8;

    // One extra bit so that a completely full FIFO (count == depth) is representable.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/xor_result_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, forces count to zero
//   clr_i  : clear request
//   inc_i  : increment request; holds at all-ones once saturated
//   cnt_o  : current count
// IncOverClr selects the result when clear and increment coincide:
//   1 -> count becomes 1 (the increment event is kept), 0 -> count becomes 0.
module sat_counter #(
    parameter int unsigned Width      = 8,
    parameter bit          IncOverClr = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i && inc_i) begin
            cnt_d = IncOverClr ? Width'(1) : '0;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/xor_result_buffer.sv
// Result buffer behind the XOR stage: a small FIFO with no upstream
// backpressure, plus drop statistics and a running XOR checksum of accepted words.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (pointers, count, stats; not storage)
//   in_valid  : upstream word valid (cannot be stalled)
//   in_data   : upstream word
//   out_valid : head entry available
//   out_ready : consumer accepts head
//   out_data  : head entry (combinational read of storage)
//   count     : occupancy, 0..DEPTH
//   overflow  : sticky, set when a word is dropped
//   drop_cnt  : saturating count of dropped words
//   checksum  : XOR of all accepted words since reset/clear
//   clr_stats : clears overflow, drop_cnt and checksum; same-cycle events win
module xor_result_buffer
    import xor_result_buffer_pkg::*;
#(
    parameter int unsigned W     = DefaultW,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic [DropCntW-1:0]   drop_cnt,
    output logic [W-1:0]          checksum,
    input  logic                  clr_stats
);

    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam int unsigned CountW = count_width(DEPTH);

    logic [W-1:0]      mem_q [DEPTH];
    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [W-1:0]      checksum_q, checksum_d;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign full = (count_q == CountW'(DEPTH));
    assign pop  = out_valid && out_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CountW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CountW'(1);
        end
    end

    // Clear is applied first, then the same-cycle event on top of it.
    always_comb begin
        checksum_d = clr_stats ? '0 : checksum_q;
        overflow_d = clr_stats ? 1'b0 : overflow_q;
        if (push) begin
            checksum_d = checksum_d ^ in_data;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            checksum_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            checksum_q <= checksum_d;
        end
    end

    // Storage is deliberately not reset; out_data is meaningless while empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    sat_counter #(
        .Width      (DropCntW),
        .IncOverClr (1'b1)
    ) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_stats),
        .inc_i (drop),
        .cnt_o (drop_cnt)
    );

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign checksum  = checksum_q;

endmodule
